// File: rtl/spi_master.sv
// SPI-style frame master: sends {op, payload} MSB first, optionally turns around and reads a byte.
// Latency: accept -> SS_n low next cycle; write frames 12 busy cycles; read frames 21+TURN busy cycles (at IDLE_GAP=1).
// Backpressure: cmd_ready is high only in IDLE; a command held valid is taken on the first IDLE cycle.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_op (2b) and cmd_data (8b) are captured on accept
//   rsp_valid/rsp_data    one-cycle pulse with the byte read on MISO; rsp_data holds until the next read
//   busy                  high whenever the block is not IDLE
//   SS_n, MOSI, MISO      serial interface; SS_n and MOSI are registered
module spi_master #(
  parameter int TURN     = 2,  // 1..15 turnaround cycles before the first MISO sample
  parameter int IDLE_GAP = 1   // 1..15 cycles of SS_n high after each frame
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SHIFT, S_TURN, S_RECV, S_DONE, S_GAP
  } state_t;

  // Counter reload values: each counted state runs from its load value down to zero.
  localparam logic [3:0] LD_SHIFT = 4'd9;
  localparam logic [3:0] LD_RECV  = 4'd7;
  localparam logic [3:0] LD_TURN  = 4'(TURN - 1);
  localparam logic [3:0] LD_GAP   = 4'(IDLE_GAP - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [9:0] r_frame;
  logic [7:0] r_rx;
  logic [7:0] r_rsp_data;
  logic       r_ss_n;
  logic       r_mosi;
  logic       w_ss_n_nxt;
  logic       w_mosi_nxt;
  logic       w_accept;

  assign w_accept  = cmd_valid && (r_state == S_IDLE);
  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = (r_state == S_DONE);
  assign rsp_data  = r_rsp_data;
  assign SS_n      = r_ss_n;
  assign MOSI      = r_mosi;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = 4'd0;
        end
      end
      S_START: begin
        w_state_nxt = S_SHIFT;
        w_cnt_nxt   = LD_SHIFT;
      end
      S_SHIFT: begin
        if (r_cnt == 4'd0) begin
          if (r_frame[9:8] == 2'b11) begin
            w_state_nxt = S_TURN;
            w_cnt_nxt   = LD_TURN;
          end else begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = LD_GAP;
          end
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_TURN: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_RECV;
          w_cnt_nxt   = LD_RECV;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RECV: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_GAP;
        w_cnt_nxt   = LD_GAP;
      end
      S_GAP: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase

    // Pin values are decoded from the next state so the registered pins line up with the state.
    // In SHIFT the down-counter doubles as the bit index, giving MSB-first order.
    w_ss_n_nxt = !(w_state_nxt inside {S_START, S_SHIFT, S_TURN, S_RECV});
    w_mosi_nxt = (w_state_nxt == S_SHIFT) ? r_frame[w_cnt_nxt] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_frame    <= 10'd0;
      r_rx       <= 8'd0;
      r_rsp_data <= 8'd0;
      r_ss_n     <= 1'b1;
      r_mosi     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ss_n  <= w_ss_n_nxt;
      r_mosi  <= w_mosi_nxt;
      if (w_accept) begin
        r_frame <= {cmd_op, cmd_data};
      end
      if (r_state == S_RECV) begin
        r_rx <= {r_rx[6:0], MISO};
      end
      // The last MISO bit is folded in directly so rsp_data is valid during DONE.
      if (r_state == S_RECV && r_cnt == 4'd0) begin
        r_rsp_data <= {r_rx[6:0], MISO};
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid_a [3];
  logic       cmd_ready_a [3];
  logic [1:0] cmd_op_a    [3];
  logic [7:0] cmd_data_a  [3];
  logic       rsp_valid_a [3];
  logic [7:0] rsp_data_a  [3];
  logic       busy_a      [3];
  logic       ss_n_a      [3];
  logic       mosi_a      [3];
  logic       miso_a      [3];

  int n_chk = 0;
  int n_err = 0;

  // Slave / RAM model state (written only by the model process).
  logic       in_frame  [3];
  int         idx       [3];
  logic [9:0] fr        [3];
  logic [9:0] last_frame[3];
  logic [7:0] addr      [3];
  logic [7:0] tx        [3];
  logic [7:0] mem       [3][256];
  int         last_len  [3] = '{0, 0, 0};
  int         frames    [3] = '{0, 0, 0};
  int         rsp_cnt   [3] = '{0, 0, 0};
  int         gap_run   [3] = '{0, 0, 0};
  int         last_gap  [3] = '{0, 0, 0};

  spi_master u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid_a[0]), .cmd_ready(cmd_ready_a[0]),
    .cmd_op(cmd_op_a[0]), .cmd_data(cmd_data_a[0]),
    .rsp_valid(rsp_valid_a[0]), .rsp_data(rsp_data_a[0]),
    .busy(busy_a[0]), .SS_n(ss_n_a[0]), .MOSI(mosi_a[0]), .MISO(miso_a[0])
  );

  spi_master #(.TURN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid_a[1]), .cmd_ready(cmd_ready_a[1]),
    .cmd_op(cmd_op_a[1]), .cmd_data(cmd_data_a[1]),
    .rsp_valid(rsp_valid_a[1]), .rsp_data(rsp_data_a[1]),
    .busy(busy_a[1]), .SS_n(ss_n_a[1]), .MOSI(mosi_a[1]), .MISO(miso_a[1])
  );

  spi_master #(.TURN(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid_a[2]), .cmd_ready(cmd_ready_a[2]),
    .cmd_op(cmd_op_a[2]), .cmd_data(cmd_data_a[2]),
    .rsp_valid(rsp_valid_a[2]), .rsp_data(rsp_data_a[2]),
    .busy(busy_a[2]), .SS_n(ss_n_a[2]), .MOSI(mosi_a[2]), .MISO(miso_a[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int turn_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  // Slave model: counts SS_n-low cycles, captures MOSI, serves a byte RAM over MISO
  // aligned so the first RECV sample sees bit 7.
  always @(negedge clk) begin : slave_model
    int rb;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        in_frame[i] = 1'b0;
        miso_a[i]   = 1'b0;
        gap_run[i]  = 0;
      end else begin
        if (rsp_valid_a[i]) rsp_cnt[i]++;
        if (!ss_n_a[i]) begin
          if (!in_frame[i]) begin
            in_frame[i] = 1'b1;
            idx[i]      = 0;
            fr[i]       = 10'd0;
            frames[i]++;
            last_gap[i] = gap_run[i];
          end else begin
            idx[i]++;
          end
          if (idx[i] >= 1 && idx[i] <= 10) fr[i] = {fr[i][8:0], mosi_a[i]};
          if (idx[i] == 10) tx[i] = mem[i][addr[i]];
          rb = idx[i] - 11 - turn_of(i);
          if (rb >= 0 && rb < 8) miso_a[i] = tx[i][7 - rb];
          else miso_a[i] = 1'b0;
        end else begin
          miso_a[i] = 1'b0;
          if (in_frame[i]) begin
            in_frame[i]   = 1'b0;
            last_len[i]   = idx[i] + 1;
            last_frame[i] = fr[i];
            case (fr[i][9:8])
              2'b00:   addr[i] = fr[i][7:0];
              2'b01:   mem[i][addr[i]] = fr[i][7:0];
              2'b10:   addr[i] = fr[i][7:0];
              default: ;
            endcase
            gap_run[i] = 1;
          end else begin
            gap_run[i]++;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and wait for the block to return to IDLE; bcyc = busy cycles seen.
  task automatic do_cmd(input int i, input logic [1:0] op, input logic [7:0] d, output int bcyc);
    int t;
    @(negedge clk);
    cmd_valid_a[i] = 1'b1;
    cmd_op_a[i]    = op;
    cmd_data_a[i]  = d;
    t = 0;
    while (!cmd_ready_a[i] && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    cmd_valid_a[i] = 1'b0;
    bcyc = 0;
    while (busy_a[i] && bcyc < 100) begin
      bcyc++;
      @(negedge clk);
    end
    chk("cmd_complete", {31'd0, busy_a[i]}, 32'd0);
  endtask

  initial begin : stim
    int bc;
    int f0;
    int r0;
    int n;
    int t;
    for (int i = 0; i < 3; i++) begin
      cmd_valid_a[i] = 1'b0;
      cmd_op_a[i]    = 2'b00;
      cmd_data_a[i]  = 8'h00;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ss_n",      {31'd0, ss_n_a[0]},      32'd1);
    chk("rst_mosi",      {31'd0, mosi_a[0]},      32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid_a[0]}, 32'd0);
    chk("rst_rsp_data",  {24'd0, rsp_data_a[0]},  32'h00);
    chk("rst_busy",      {31'd0, busy_a[0]},      32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", {31'd0, cmd_ready_a[0]}, 32'd1);

    // Write address 0x3C
    do_cmd(0, 2'b00, 8'h3C, bc);
    chk("wa_ss_len",   last_len[0],              32'd11);
    chk("wa_mosi",     {22'd0, last_frame[0]},   32'h03C);
    chk("wa_busy",     bc,                       32'd12);
    chk("wa_no_rsp",   rsp_cnt[0],               32'd0);
    chk("wa_rsp_data", {24'd0, rsp_data_a[0]},   32'h00);

    // Write data 0xA5 to 0x3C, then read it back with a rd-data frame
    do_cmd(0, 2'b01, 8'hA5, bc);
    chk("wd_mosi",     {22'd0, last_frame[0]},   32'h1A5);
    do_cmd(0, 2'b11, 8'h00, bc);
    chk("rd_ss_len",   last_len[0],              32'd21);
    chk("rd_mosi",     {22'd0, last_frame[0]},   32'h300);
    chk("rd_busy",     bc,                       32'd23);
    chk("rd_rsp_cnt",  rsp_cnt[0],               32'd1);
    chk("rd_rsp_data", {24'd0, rsp_data_a[0]},   32'hA5);

    // rd-addr must not disturb the held response byte
    do_cmd(0, 2'b10, 8'h77, bc);
    chk("ra_ss_len",   last_len[0],              32'd11);
    chk("ra_hold",     {24'd0, rsp_data_a[0]},   32'hA5);

    // cmd_valid held high across three commands
    f0 = frames[0];
    @(negedge clk);
    cmd_valid_a[0] = 1'b1;
    cmd_op_a[0]    = 2'b00;
    cmd_data_a[0]  = 8'h3C;
    n = 0;
    t = 0;
    while (n < 3 && t < 200) begin
      if (cmd_ready_a[0]) n++;
      @(negedge clk);
      t++;
    end
    cmd_valid_a[0] = 1'b0;
    t = 0;
    while (busy_a[0] && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("b2b_accepts", frames[0] - f0,           32'd3);
    chk("b2b_gap",     last_gap[0],              32'd2);
    chk("b2b_ss_len",  last_len[0],              32'd11);
    chk("b2b_hold",    {24'd0, rsp_data_a[0]},   32'hA5);

    // Reset during SHIFT bit 5 of a read frame
    r0 = rsp_cnt[0];
    @(negedge clk);
    cmd_valid_a[0] = 1'b1;
    cmd_op_a[0]    = 2'b11;
    cmd_data_a[0]  = 8'h00;
    @(negedge clk);
    cmd_valid_a[0] = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ab_ss_n",     {31'd0, ss_n_a[0]},       32'd1);
    chk("ab_busy",     {31'd0, busy_a[0]},       32'd0);
    chk("ab_rsp_data", {24'd0, rsp_data_a[0]},   32'h00);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("ab_no_rsp",   rsp_cnt[0] - r0,          32'd0);

    // Full loop through the RAM slave after reset
    do_cmd(0, 2'b00, 8'h10, bc);
    do_cmd(0, 2'b01, 8'h5A, bc);
    do_cmd(0, 2'b10, 8'h10, bc);
    do_cmd(0, 2'b11, 8'h00, bc);
    chk("loop_rsp_data", {24'd0, rsp_data_a[0]}, 32'h5A);
    chk("loop_rsp_cnt",  rsp_cnt[0] - r0,        32'd1);
    chk("loop_ss_len",   last_len[0],            32'd21);

    // TURN sweep: TURN=1 and TURN=4
    do_cmd(1, 2'b00, 8'h22, bc);
    do_cmd(1, 2'b01, 8'hC3, bc);
    do_cmd(1, 2'b11, 8'h00, bc);
    chk("t1_ss_len",   last_len[1],              32'd20);
    chk("t1_busy",     bc,                       32'd22);
    chk("t1_rsp_data", {24'd0, rsp_data_a[1]},   32'hC3);
    chk("t1_rsp_cnt",  rsp_cnt[1],               32'd1);

    do_cmd(2, 2'b00, 8'h22, bc);
    do_cmd(2, 2'b01, 8'h96, bc);
    do_cmd(2, 2'b11, 8'h00, bc);
    chk("t4_ss_len",   last_len[2],              32'd23);
    chk("t4_busy",     bc,                       32'd25);
    chk("t4_rsp_data", {24'd0, rsp_data_a[2]},   32'h96);
    chk("t4_rsp_cnt",  rsp_cnt[2],               32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: TURN, default 2, cycles between the last MOSI bit of a read-data frame and the first MISO sample (range 1..15).
REQ-002 Parameter: IDLE_GAP, default 1, minimum cycles SS_n stays high between frames (range 1..15).
REQ-003 One clock; reset is asynchronous and active-low (ports clk, rst_n).
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 cmd_valid  input  1  host command request.
REQ-007 cmd_ready  output  1  block can accept a command this cycle.
REQ-008 cmd_op  input  2  frame opcode: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
REQ-009 cmd_data  input  8  address or data payload; don't-care for op 11.
REQ-010 rsp_valid  output  1  one-cycle pulse, rsp_data holds read byte.
REQ-011 rsp_data  output  8  last byte received on MISO.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 SS_n  output  1  slave select, active low, registered.
REQ-014 MOSI  output  1  serial data to slave, registered.
REQ-015 MISO  input  1  serial data from slave.

Function
REQ-016 States: IDLE, START, SHIFT, TURN, RECV, DONE, GAP; cmd_ready = 1 only in IDLE.
REQ-017 Handshake: command accepted on a rising edge with cmd_valid && cmd_ready; cmd_op and cmd_data latched into a 10-bit frame {cmd_op, cmd_data}; inputs ignored at all other times.
REQ-018 IDLE -> START on accept; START lasts 1 cycle with SS_n = 0, MOSI = 0.
REQ-019 SHIFT: 10 cycles, SS_n = 0, MOSI = frame[9] first down to frame[0], one bit per cycle, MSB first.
REQ-020 After SHIFT: op != 11 -> GAP; op 11 -> TURN.
REQ-021 TURN: TURN cycles, SS_n = 0, MOSI = 0, MISO ignored.
REQ-022 RECV: 8 cycles, SS_n = 0, MISO sampled each rising edge, shifted in MSB first.
REQ-023 DONE: 1 cycle, SS_n = 1, rsp_valid = 1, rsp_data = assembled byte; then GAP.
REQ-024 rsp_data holds its value until the next DONE; never changes on write or rd-addr frames.
REQ-025 GAP: IDLE_GAP cycles, SS_n = 1, MOSI = 0; then IDLE.
REQ-026 SS_n low duration: 11 cycles for ops 00/01/10; 19+TURN cycles for op 11 (21 at defaults).
REQ-027 cmd_valid held high continuously: the next command is accepted on the first IDLE cycle; no back-to-back frames without GAP.
REQ-028 A single bit counter (4 bits) serves SHIFT, TURN, RECV and GAP; it reloads on every state entry and never wraps within a state.
REQ-029 Outside START..RECV, SS_n = 1 and MOSI = 0.

Reset
REQ-030 rst_n low forces within the same cycle: state IDLE, SS_n = 1, MOSI = 0, rsp_valid = 0, rsp_data = 0x00, busy = 0, counters and frame = 0; cmd_ready = 1 after release.
REQ-031 Reset asserted mid-frame aborts the frame; no rsp_valid is produced for it; the first rising edge after release may accept a new command.

Verification
REQ-032 Write address: op 00, data 0x3C -> SS_n low 11 cycles; MOSI after START = 0,0,0,0,1,1,1,1,0,0; no rsp_valid; cmd_ready returns after 1 GAP cycle.
REQ-033 Read data: op 11, MISO model drives 0xA5 MSB first aligned to RECV -> rsp_valid one cycle, rsp_data = 0xA5; SS_n low 21 cycles.
REQ-034 Full loop with RAM/slave pair: wr-addr 0x10, wr-data 0x5A, rd-addr 0x10, rd-data -> rsp_data = 0x5A.
REQ-035 cmd_valid held high for 3 commands -> exactly 3 accepts, each separated by >= IDLE_GAP cycles of SS_n = 1.
REQ-036 rst_n pulsed low at SHIFT bit 5 of a read frame -> SS_n = 1 immediately, no rsp_valid, rsp_data = 0x00, next command completes normally.
REQ-037 Sweep TURN = 1 and 4 -> SS_n low duration 20 and 23 cycles for op 11, data still correct with aligned MISO model.
